cc_unit: RTL

//  Consumer side of the ALU flag interface: latches SF/ZF/OF from the ALU into the Y86

---
 rtl/cc_unit_pkg.sv | 24 ++
 rtl/cc_unit_if.sv | 33 +++
 rtl/cc_unit_cond_eval.sv | 32 +++
 rtl/cc_unit.sv | 119 +++++++++++
 4 files changed

// File: rtl/cc_unit_pkg.sv
// Shared Y86 definitions for the execute-stage condition-code unit:
// instruction codes, jXX/cmovXX condition encodings and CC bit positions.
package cc_unit_pkg;

  localparam logic [3:0] I_RRMOVL = 4'd2;
  localparam logic [3:0] I_OPL    = 4'd6;
  localparam logic [3:0] I_JXX    = 4'd7;

  typedef enum logic [3:0] {
    C_ALWAYS = 4'd0,
    C_LE     = 4'd1,
    C_L      = 4'd2,
    C_E      = 4'd3,
    C_NE     = 4'd4,
    C_GE     = 4'd5,
    C_G      = 4'd6
  } cond_e;

  // CC register layout is {ZF,SF,OF}
  localparam int ZF = 2;
  localparam int SF = 1;
  localparam int OF = 0;

endpackage

// File: rtl/cc_unit_if.sv
// Execute-stage bundle between pipeline control / ALU and the condition-code unit.
// The master side drives instruction, flags and control; the slave side returns results.
interface cc_unit_if #(parameter int CNT_W = 16);

  logic             in_valid;
  logic [3:0]       icode;
  logic [3:0]       ifun;
  logic             set_cc;
  logic             alu_sf;
  logic             alu_zf;
  logic             alu_of;
  logic             exc;
  logic             stall;
  logic             bubble;
  logic [2:0]       cc;
  logic             cnd;
  logic             cnd_valid;
  logic             mispredict;
  logic             bad_cond;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] mispredict_count;

  modport master (
    output in_valid, icode, ifun, set_cc, alu_sf, alu_zf, alu_of, exc, stall, bubble,
    input  cc, cnd, cnd_valid, mispredict, bad_cond, branch_count, mispredict_count
  );

  modport slave (
    input  in_valid, icode, ifun, set_cc, alu_sf, alu_zf, alu_of, exc, stall, bubble,
    output cc, cnd, cnd_valid, mispredict, bad_cond, branch_count, mispredict_count
  );

endinterface

// File: rtl/cc_unit_cond_eval.sv
// Combinational jXX/cmovXX condition evaluator over a {ZF,SF,OF} flag vector.
// Unused condition codes (7..15) evaluate false and raise bad.
module cc_unit_cond_eval
  import cc_unit_pkg::*;
(
  input  logic [3:0] ifun,
  input  logic [2:0] cc,
  output logic       eval,
  output logic       bad
);

  logic lt_s;

  assign lt_s = cc[SF] ^ cc[OF];

  // Decode the condition code against the current flags
  always_comb begin
    eval = 1'b0;
    bad  = 1'b0;
    case (ifun)
      C_ALWAYS: eval = 1'b1;
      C_LE:     eval = lt_s | cc[ZF];
      C_L:      eval = lt_s;
      C_E:      eval = cc[ZF];
      C_NE:     eval = ~cc[ZF];
      C_GE:     eval = ~lt_s;
      C_G:      eval = ~lt_s & ~cc[ZF];
      default:  bad  = 1'b1;
    endcase
  end

endmodule

// File: rtl/cc_unit.sv
// Y86 condition-code register plus execute-output register: latches ALU flags on OPl,
// evaluates jXX/cmovXX, flags mispredicts and keeps saturating branch/mispredict counters.
module cc_unit
  import cc_unit_pkg::*;
#(
  parameter int         CNT_W    = 16,
  parameter logic [2:0] CC_RESET = 3'b100
)
(
  input logic      clock,
  input logic      reset,
  cc_unit_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [2:0]       cc_q, cc_d;
  logic             frozen_q, frozen_d;
  logic             cnd_q, cnd_d;
  logic             cnd_valid_q, cnd_valid_d;
  logic             mispredict_q, mispredict_d;
  logic             bad_cond_q, bad_cond_d;
  logic [CNT_W-1:0] branch_count_q, branch_count_d;
  logic [CNT_W-1:0] mispredict_count_q, mispredict_count_d;

  logic raw_eval_s, raw_bad_s, is_jxx_s, is_cond_s, eval_s, bad_s, cc_we_s;

  cc_unit_cond_eval u_cond_eval (
    .ifun (bus.ifun),
    .cc   (cc_q),
    .eval (raw_eval_s),
    .bad  (raw_bad_s)
  );

  assign is_jxx_s  = (bus.icode == I_JXX);
  assign is_cond_s = is_jxx_s | (bus.icode == I_RRMOVL);
  assign eval_s    = is_cond_s & raw_eval_s;
  assign bad_s     = is_cond_s & raw_bad_s;
  // A squashed (exception) or frozen pipeline must never alter the flags
  assign cc_we_s   = bus.in_valid & (bus.icode == I_OPL) & bus.set_cc & ~bus.stall
                     & ~bus.bubble & ~bus.exc & ~frozen_q;

  // Next-state for CC, frozen flag, execute-output register and counters
  always_comb begin
    cc_d               = cc_q;
    frozen_d           = frozen_q;
    cnd_d              = cnd_q;
    cnd_valid_d        = cnd_valid_q;
    mispredict_d       = mispredict_q;
    bad_cond_d         = bad_cond_q;
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;

    if (bus.stall) begin
      frozen_d = frozen_q;
    end else if (bus.bubble) begin
      cnd_d        = 1'b0;
      cnd_valid_d  = 1'b0;
      mispredict_d = 1'b0;
      bad_cond_d   = 1'b0;
      frozen_d     = frozen_q | bus.exc;
    end else begin
      cnd_valid_d  = bus.in_valid;
      cnd_d        = bus.in_valid & eval_s;
      mispredict_d = bus.in_valid & is_jxx_s & ~eval_s;
      bad_cond_d   = bus.in_valid & bad_s;
      frozen_d     = frozen_q | bus.exc;
      if (bus.in_valid && is_jxx_s && (branch_count_q != CNT_MAX)) begin
        branch_count_d = branch_count_q + CNT_ONE;
      end else begin
        branch_count_d = branch_count_q;
      end
      if (mispredict_d && (mispredict_count_q != CNT_MAX)) begin
        mispredict_count_d = mispredict_count_q + CNT_ONE;
      end else begin
        mispredict_count_d = mispredict_count_q;
      end
    end

    if (cc_we_s) begin
      cc_d = {bus.alu_zf, bus.alu_sf, bus.alu_of};
    end else begin
      cc_d = cc_q;
    end
  end

  // State registers with synchronous reset taking priority over stall/bubble
  always_ff @(posedge clock) begin
    if (reset) begin
      cc_q               <= CC_RESET;
      frozen_q           <= 1'b0;
      cnd_q              <= 1'b0;
      cnd_valid_q        <= 1'b0;
      mispredict_q       <= 1'b0;
      bad_cond_q         <= 1'b0;
      branch_count_q     <= {CNT_W{1'b0}};
      mispredict_count_q <= {CNT_W{1'b0}};
    end else begin
      cc_q               <= cc_d;
      frozen_q           <= frozen_d;
      cnd_q              <= cnd_d;
      cnd_valid_q        <= cnd_valid_d;
      mispredict_q       <= mispredict_d;
      bad_cond_q         <= bad_cond_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign bus.cc               = cc_q;
  assign bus.cnd              = cnd_q;
  assign bus.cnd_valid        = cnd_valid_q;
  assign bus.mispredict       = mispredict_q;
  assign bus.bad_cond         = bad_cond_q;
  assign bus.branch_count     = branch_count_q;
  assign bus.mispredict_count = mispredict_count_q;

endmodule
